// File: rtl/kbd_link_rx_if.sv
// Key-event link bundle: host-side serial line in, key matrix and event pulses out.
interface kbd_link_rx_if;
    logic        rxd;
    logic [63:0] kbmat;
    logic        evt;
    logic        ferr;

    modport master (output rxd, input kbmat, evt, ferr);
    modport slave  (input rxd, output kbmat, evt, ferr);
endinterface

// File: rtl/kbd_link_rx.sv
// 8N1 UART key-event receiver owning the 64-bit keyboard matrix; no backpressure.
// kbmat/evt/ferr are registered on the stop-bit sample edge (t0+H+9C), visible from t0+H+9C+1.
module kbd_link_rx #(
    parameter int CLKS_PER_BIT = 85
) (
    input  logic         mck,
    input  logic         rin,
    kbd_link_rx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_sync;
    logic        w_rxs;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [7:0]  r_sh, w_sh_nxt;
    logic [63:0] r_kbmat, w_kbmat_nxt;
    logic        r_evt, w_evt_nxt;
    logic        r_ferr, w_ferr_nxt;
    logic        w_cnt_done;

    assign w_rxs      = r_sync[1];
    assign w_cnt_done = (r_cnt == '0);

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_sh    <= '0;
            r_kbmat <= '0;
            r_evt   <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], bus.rxd};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_sh    <= w_sh_nxt;
            r_kbmat <= w_kbmat_nxt;
            r_evt   <= w_evt_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_sh_nxt    = r_sh;
        w_kbmat_nxt = r_kbmat;
        w_evt_nxt   = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rxs) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = HALF_M1;
                end
            end
            S_START: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = FULL_M1;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_sh_nxt  = {w_rxs, r_sh[7:1]};
                    w_cnt_nxt = FULL_M1;
                    w_bit_nxt = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (!w_cnt_done) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_rxs) begin
                    // 0PIIIIII sets/clears one key, 0x80 clears all, other 1xxxxxxx are no-ops
                    w_state_nxt = S_IDLE;
                    w_evt_nxt   = 1'b1;
                    if (!r_sh[7]) begin
                        w_kbmat_nxt[r_sh[5:0]] = r_sh[6];
                    end else if (r_sh == 8'h80) begin
                        w_kbmat_nxt = '0;
                    end
                end else begin
                    w_state_nxt = S_BRK;
                    w_ferr_nxt  = 1'b1;
                end
            end
            S_BRK: begin
                if (w_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.kbmat = r_kbmat;
    assign bus.evt   = r_evt;
    assign bus.ferr  = r_ferr;
endmodule

// File: tb/tb_kbd_link_rx.sv
// Directed plus randomized bench for kbd_link_rx at 8 and 85 clocks per bit.
module tb_kbd_link_rx;
    logic mck    = 1'b0;
    logic rin    = 1'b1;
    logic r_rxd8  = 1'b1;
    logic r_rxd85 = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    int evt8 = 0, ferr8 = 0, evt85 = 0, ferr85 = 0, evt8_edge = -1, overlap = 0;

    always #5 mck = ~mck;
    always @(posedge mck) cyc <= cyc + 1;

    kbd_link_rx_if if8();
    kbd_link_rx_if if85();
    assign if8.rxd  = r_rxd8;
    assign if85.rxd = r_rxd85;

    kbd_link_rx #(.CLKS_PER_BIT(8))  u_dut8  (.mck(mck), .rin(rin), .bus(if8.slave));
    kbd_link_rx #(.CLKS_PER_BIT(85)) u_dut85 (.mck(mck), .rin(rin), .bus(if85.slave));

    // Pulse counters; a pulse seen here belongs to the next rising edge
    always @(negedge mck) begin
        if (if8.evt === 1'b1) begin
            evt8++;
            evt8_edge = cyc + 1;
        end
        if (if8.ferr === 1'b1) ferr8++;
        if (if85.evt === 1'b1) evt85++;
        if (if85.ferr === 1'b1) ferr85++;
        if ((if8.evt === 1'b1 && if8.ferr === 1'b1) || (if85.evt === 1'b1 && if85.ferr === 1'b1))
            overlap++;
    end

    initial begin
        #3000000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] apply(input logic [63:0] m, input logic [7:0] b);
        if (b < 8'h80) m[b[5:0]] = b[6];
        else if (b == 8'h80) m = '0;
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rxd(input bit sel, input logic v);
        if (sel) r_rxd85 = v;
        else     r_rxd8  = v;
    endtask

    // Called on a falling edge; returns on the falling edge after the stop bit ends
    task automatic send(input bit sel, input logic [7:0] b, input int per, input logic stop,
                        output int t0);
        t0 = cyc + 3;
        set_rxd(sel, 1'b0);
        repeat (per) @(negedge mck);
        for (int i = 0; i < 8; i++) begin
            set_rxd(sel, b[i]);
            repeat (per) @(negedge mck);
        end
        set_rxd(sel, stop);
        repeat (per) @(negedge mck);
    endtask

    initial begin
        int t0, e0, f0, per;
        logic [63:0] m8, m85;
        logic [7:0] b;
        logic [7:0] seq [4];
        m8  = '0;
        m85 = '0;

        // Reset
        rin = 1'b1;
        repeat (3) @(posedge mck);
        @(negedge mck);
        rin = 1'b0;
        check("rst_kbmat", if8.kbmat, 64'd0);
        check("rst_evt", {63'd0, if8.evt}, 64'd0);
        check("rst_ferr", {63'd0, if8.ferr}, 64'd0);
        repeat (200) @(negedge mck);
        check("idle_kbmat8", if8.kbmat, 64'd0);
        check("idle_kbmat85", if85.kbmat, 64'd0);
        check("idle_pulses", 64'(evt8 + ferr8 + evt85 + ferr85), 64'd0);

        // Press and release
        e0 = evt8;
        send(0, 8'h45, 8, 1'b1, t0);
        m8 = apply(m8, 8'h45);
        check("press_kbmat", if8.kbmat, 64'h20);
        check("press_evt_cnt", 64'(evt8 - e0), 64'd1);
        check("press_evt_time", 64'(evt8_edge), 64'(t0 + 4 + 72 + 1));
        e0 = evt8;
        send(0, 8'h05, 8, 1'b1, t0);
        m8 = apply(m8, 8'h05);
        check("release_kbmat", if8.kbmat, m8);
        check("release_evt_cnt", 64'(evt8 - e0), 64'd1);

        // Multiple keys, clear-all, ignored command
        seq = '{8'h7F, 8'h40, 8'h5A, 8'h47};
        for (int i = 0; i < 3; i++) begin
            send(0, seq[i], 8, 1'b1, t0);
            m8 = apply(m8, seq[i]);
        end
        check("multi_kbmat", if8.kbmat, 64'h8000_0000_0400_0001);
        send(0, 8'h80, 8, 1'b1, t0);
        m8 = apply(m8, 8'h80);
        check("clear_kbmat", if8.kbmat, 64'd0);
        send(0, seq[3], 8, 1'b1, t0);
        m8 = apply(m8, seq[3]);
        e0 = evt8;
        send(0, 8'hC3, 8, 1'b1, t0);
        m8 = apply(m8, 8'hC3);
        check("ignored_kbmat", if8.kbmat, m8);
        check("ignored_evt_cnt", 64'(evt8 - e0), 64'd1);

        // Framing error followed by a long break
        e0 = evt8;
        f0 = ferr8;
        send(0, 8'h41, 8, 1'b0, t0);
        repeat (30 * 8) @(negedge mck);
        set_rxd(0, 1'b1);
        repeat (16) @(negedge mck);
        check("ferr_cnt", 64'(ferr8 - f0), 64'd1);
        check("ferr_no_evt", 64'(evt8 - e0), 64'd0);
        check("ferr_kbmat", if8.kbmat, m8);
        send(0, 8'h41, 8, 1'b1, t0);
        m8 = apply(m8, 8'h41);
        check("after_brk_kbmat", if8.kbmat, m8);

        // Glitch on idle line
        e0 = evt8;
        f0 = ferr8;
        set_rxd(0, 1'b0);
        repeat (2) @(negedge mck);
        set_rxd(0, 1'b1);
        repeat (100) @(negedge mck);
        check("glitch_pulses", 64'((evt8 - e0) + (ferr8 - f0)), 64'd0);
        send(0, 8'h4A, 8, 1'b1, t0);
        m8 = apply(m8, 8'h4A);
        check("post_glitch_kbmat", if8.kbmat, m8);

        // Reset in the middle of a frame
        e0 = evt8;
        f0 = ferr8;
        b  = 8'h4F;
        set_rxd(0, 1'b0);
        repeat (8) @(negedge mck);
        for (int i = 0; i < 4; i++) begin
            set_rxd(0, b[i]);
            repeat (8) @(negedge mck);
        end
        rin = 1'b1;
        repeat (3) @(negedge mck);
        set_rxd(0, 1'b1);
        rin = 1'b0;
        m8  = '0;
        m85 = '0;
        repeat (120) @(negedge mck);
        check("midrst_kbmat", if8.kbmat, 64'd0);
        check("midrst_pulses", 64'((evt8 - e0) + (ferr8 - f0)), 64'd0);

        // Back-to-back at -4.7 % and +4.7 % baud
        for (int r = 0; r < 2; r++) begin
            per = (r == 0) ? 81 : 89;
            e0  = evt85;
            for (int k = 0; k < 8; k++) begin
                send(1, 8'(8'h40 + k), per, 1'b1, t0);
                m85 = apply(m85, 8'(8'h40 + k));
            end
            repeat (20) @(negedge mck);
            check("b2b_kbmat_lo", {56'd0, if85.kbmat[7:0]}, 64'hFF);
            check("b2b_kbmat", if85.kbmat, m85);
            check("b2b_evt_cnt", 64'(evt85 - e0), 64'd8);
            send(1, 8'h80, 85, 1'b1, t0);
            m85 = apply(m85, 8'h80);
        end
        check("b2b_ferr", 64'(ferr85), 64'd0);

        // Random traffic at nominal rate
        e0 = evt8;
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) b = 8'h80;
            else if ($urandom_range(0, 3) != 0) b[7] = 1'b0;
            send(0, b, 8, 1'b1, t0);
            m8 = apply(m8, b);
            check("rand8_kbmat", if8.kbmat, m8);
        end
        check("rand8_evt_cnt", 64'(evt8 - e0), 64'd24);

        // Random traffic with random baud error
        e0 = evt85;
        for (int k = 0; k < 10; k++) begin
            b = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) b = 8'h80;
            per = $urandom_range(82, 88);
            send(1, b, per, 1'b1, t0);
            m85 = apply(m85, b);
            check("rand85_kbmat", if85.kbmat, m85);
        end
        check("rand85_evt_cnt", 64'(evt85 - e0), 64'd10);
        check("no_evt_ferr_overlap", 64'(overlap), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
